// File: rtl/yasac_pkg.sv
// Shared definitions for the YASAC data path: ALU op encodings, status bit
// indices, instruction field positions and the memory FSM state type.
package yasac_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_NOT   = 4'h5,
        ALU_PASSA = 4'h6,
        ALU_PASSB = 4'h7,
        ALU_SHL   = 4'h8,
        ALU_SHR   = 4'h9,
        ALU_INC   = 4'hA,
        ALU_DEC   = 4'hB
    } alu_op_e;

    localparam int unsigned ST_C = 0;
    localparam int unsigned ST_Z = 1;
    localparam int unsigned ST_N = 2;
    localparam int unsigned ST_V = 3;

    localparam int unsigned IR_OPC_LSB = 11;
    localparam int unsigned IR_OPC_W   = 5;
    localparam int unsigned IR_S_LSB   = 8;
    localparam int unsigned IR_S_W     = 3;
    localparam int unsigned IR_K_LSB   = 0;
    localparam int unsigned IR_K_W     = 8;
    localparam int unsigned IR_SB_LSB  = 0;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/data_unit_p_if.sv
// Memory-side request/acknowledge bus of the data unit.
interface data_unit_p_if #(
    parameter int unsigned DW = 8
);
    logic          mem_req;
    logic          mem_ack;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_we,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/alu.sv
// DW-wide ALU; status carries C/Z/N/V in the low nibble, upper bits zero.
module alu
    import yasac_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic [7:0]    status
);
    logic          c;
    logic          v;
    logic [DW:0]   ext;

    always_comb begin
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ext = '0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                y   = ext[DW-1:0];
                c   = ext[DW];
                v   = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            // carry holds the borrow on subtraction
            ALU_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                y   = ext[DW-1:0];
                c   = ext[DW];
                v   = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOT:   y = ~a;
            ALU_PASSA: y = a;
            ALU_PASSB: y = b;
            ALU_SHL: begin
                y = {a[DW-2:0], 1'b0};
                c = a[DW-1];
            end
            ALU_SHR: begin
                y = {1'b0, a[DW-1:1]};
                c = a[0];
            end
            ALU_INC: begin
                ext = {1'b0, a} + (DW+1)'(1);
                y   = ext[DW-1:0];
                c   = ext[DW];
            end
            ALU_DEC: begin
                ext = {1'b0, a} - (DW+1)'(1);
                y   = ext[DW-1:0];
                c   = ext[DW];
            end
            default: y = b;
        endcase
        status       = '0;
        status[ST_C] = c;
        status[ST_Z] = (y == '0);
        status[ST_N] = y[DW-1];
        status[ST_V] = v;
    end
endmodule

// File: rtl/ret_stack.sv
// Return-address LIFO; clr has priority over pop, pop over push.
module ret_stack #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);
    localparam int unsigned SPW = $clog2(D + 1);
    localparam int unsigned IW  = $clog2(D);

    logic [SPW-1:0] sp_q, sp_d;
    logic [W-1:0]   mem_q [D];
    logic [W-1:0]   mem_d [D];
    logic [IW-1:0]  wr_idx, rd_idx;

    assign full   = (sp_q == SPW'(D));
    assign empty  = (sp_q == '0);
    assign wr_idx = IW'(sp_q);
    assign rd_idx = IW'(sp_q - SPW'(1));
    assign top    = empty ? '0 : mem_q[rd_idx];

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (clr) begin
            sp_d = '0;
        end else if (pop) begin
            if (!empty) sp_d = sp_q - SPW'(1);
        end else if (push && !full) begin
            mem_d[wr_idx] = din;
            sp_d          = sp_q + SPW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/data_unit_p.sv
// Parameterised data unit: register file, ALU, PC, IR, MAR, status and a
// request/ack memory FSM. Define YASAC_RSTACK_EN to enable call/ret stack.
module data_unit_p
    import yasac_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned RN = 8,
    parameter int unsigned PW = 8,
    parameter int unsigned SD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    op,
    input  logic          ipc,
    input  logic          clpc,
    input  logic          wpc,
    input  logic          wir,
    input  logic          wreg,
    input  logic          inm,
    input  logic          wmem,
    input  logic          rmem,
    input  logic          wmar,
    input  logic          wsreg,
    input  logic          clsb,
    input  logic          sesb,
    input  logic          call,
    input  logic          ret,
    input  logic [15:0]   inst,
    output logic [PW-1:0] pc,
    output logic [4:0]    opcode,
    output logic [2:0]    s,
    output logic [7:0]    status,
    output logic          busy,
    output logic          stk_err,
    data_unit_p_if.master mem
);
    localparam int unsigned AW = $clog2(RN);

    logic [15:0]   ir_q, ir_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [DW-1:0] mar_q, mar_d;
    logic [7:0]    status_q, status_d;
    logic [DW-1:0] regs_q [RN];
    logic [DW-1:0] regs_d [RN];
    mem_state_e    state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] tsa_q, tsa_d;
    logic          rd_q, rd_d;

    logic [AW-1:0] sa, sb;
    logic [DW-1:0] k, a_op, b_op, bus;
    logic [7:0]    alu_status;
    logic [PW-1:0] bus_pc, pc_inc;
    logic          rd_done;

    assign sa     = ir_q[IR_S_LSB +: AW];
    assign sb     = ir_q[IR_SB_LSB +: AW];
    assign k      = DW'(ir_q[IR_K_LSB +: IR_K_W]);
    assign a_op   = regs_q[sa];
    assign b_op   = inm ? k : regs_q[sb];
    assign bus_pc = PW'(bus);
    assign pc_inc = pc_q + PW'(1);

    assign pc     = pc_q;
    assign opcode = ir_q[IR_OPC_LSB +: IR_OPC_W];
    assign s      = ir_q[IR_S_LSB +: IR_S_W];
    assign status = status_q;

    alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (a_op),
        .b      (b_op),
        .y      (bus),
        .status (alu_status)
    );

`ifdef YASAC_RSTACK_EN
    logic          stk_push, stk_pop, stk_full, stk_empty;
    logic          stk_err_q, stk_err_d;
    logic [PW-1:0] stk_top;

    // ret outranks call, so at most one of push/pop reaches the stack
    assign stk_pop  = !clpc && ret;
    assign stk_push = !clpc && !ret && call;

    ret_stack #(.W(PW), .D(SD)) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clpc),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    always_comb begin
        stk_err_d = stk_err_q;
        if (clpc)                          stk_err_d = 1'b0;
        else if (stk_pop && stk_empty)     stk_err_d = 1'b1;
        else if (stk_push && stk_full)     stk_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stk_err_q <= 1'b0;
        else        stk_err_q <= stk_err_d;
    end

    assign stk_err = stk_err_q;
`else
    logic unused_stack;
    assign unused_stack = call ^ ret ^ (SD == 0);
    assign stk_err      = 1'b0;
`endif

    // A stack fault holds pc rather than falling through to ipc/wpc.
    always_comb begin
        pc_d = pc_q;
        if (clpc) begin
            pc_d = '0;
`ifdef YASAC_RSTACK_EN
        end else if (ret) begin
            if (!stk_empty) pc_d = stk_top;
        end else if (call) begin
            if (!stk_full) pc_d = bus_pc;
`endif
        end else if (ipc) begin
            pc_d = pc_inc;
        end else if (wpc) begin
            pc_d = bus_pc;
        end
    end

    always_comb begin
        ir_d     = wir  ? inst : ir_q;
        mar_d    = wmar ? bus  : mar_q;
        status_d = status_q;
        if (wsreg)     status_d    = alu_status;
        else if (clsb) status_d[s] = 1'b0;
        else if (sesb) status_d[s] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tsa_d   = tsa_q;
        rd_d    = rd_q;
        case (state_q)
            MEM_IDLE: begin
                if (rmem || wmem) begin
                    state_d = MEM_WAIT;
                    addr_d  = mar_q;
                    wdata_d = bus;
                    tsa_d   = sa;
                    rd_d    = rmem;
                end
            end
            MEM_WAIT: begin
                if (mem.mem_ack) state_d = MEM_IDLE;
            end
        endcase
    end

    assign busy          = (state_q == MEM_WAIT);
    assign rd_done       = busy && mem.mem_ack && rd_q;
    assign mem.mem_req   = busy;
    assign mem.mem_we    = busy && !rd_q;
    assign mem.mem_addr  = busy ? addr_q  : mar_q;
    assign mem.mem_wdata = busy ? wdata_q : bus;

    // read completion is applied last so it wins over wreg to the same index
    always_comb begin
        regs_d = regs_q;
        if (wreg)    regs_d[sa]    = bus;
        if (rd_done) regs_d[tsa_q] = mem.mem_rdata;
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= '0;
            pc_q     <= '0;
            mar_q    <= '0;
            status_q <= '0;
            state_q  <= MEM_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            tsa_q    <= '0;
            rd_q     <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            status_q <= status_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tsa_q    <= tsa_d;
            rd_q     <= rd_d;
        end
    end
endmodule

// File: tb/tb_data_unit_p.sv
// Directed bench for data_unit_p (DW=16, RN=8, PW=8, SD=4).
module tb_data_unit_p;
    import yasac_pkg::*;

    logic        clk, rst_n;
    logic [3:0]  op;
    logic        ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg, clsb, sesb;
    logic        call, ret;
    logic [15:0] inst;
    logic [7:0]  pc;
    logic [4:0]  opcode;
    logic [2:0]  s;
    logic [7:0]  status;
    logic        busy, stk_err;

    int n_cmp  = 0;
    int n_fail = 0;

    data_unit_p_if #(.DW(16)) mem_if ();

    data_unit_p #(.DW(16), .RN(8), .PW(8), .SD(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op),
        .ipc(ipc), .clpc(clpc), .wpc(wpc), .wir(wir), .wreg(wreg), .inm(inm),
        .wmem(wmem), .rmem(rmem), .wmar(wmar), .wsreg(wsreg), .clsb(clsb), .sesb(sesb),
        .call(call), .ret(ret), .inst(inst),
        .pc(pc), .opcode(opcode), .s(s), .status(status),
        .busy(busy), .stk_err(stk_err), .mem(mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        op = ALU_PASSB; ipc = 0; clpc = 0; wpc = 0; wir = 0; wreg = 0; inm = 0;
        wmem = 0; rmem = 0; wmar = 0; wsreg = 0; clsb = 0; sesb = 0;
        call = 0; ret = 0; inst = '0;
        mem_if.mem_ack = 0; mem_if.mem_rdata = '0;
    endtask

    task automatic load_ir(input logic [15:0] v);
        inst = v; wir = 1; cycle(); wir = 0;
    endtask

    task automatic load_reg(input logic [2:0] idx, input logic [7:0] val);
        load_ir({5'h00, idx, val});
        op = ALU_PASSB; inm = 1; wreg = 1; cycle(); wreg = 0; inm = 0;
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
        load_ir({5'h00, idx, 8'h00});
        op = ALU_PASSA; inm = 0; #1;
        val = mem_if.mem_wdata;
    endtask

    task automatic set_pc(input logic [7:0] val);
        load_ir({5'h00, 3'd0, val});
        op = ALU_PASSB; inm = 1; wpc = 1; cycle(); wpc = 0; inm = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; clr_ctl();
        cycle(); cycle();
        n_cmp++; if (pc !== 8'h00)     begin n_fail++; $display("FAIL reset_pc got=%h exp=00", pc); end
        n_cmp++; if (opcode !== 5'h00) begin n_fail++; $display("FAIL reset_opcode got=%h exp=00", opcode); end
        n_cmp++; if (s !== 3'd0)       begin n_fail++; $display("FAIL reset_s got=%h exp=0", s); end
        n_cmp++; if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%h exp=00", status); end
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_if.mem_req); end
        n_cmp++; if (mem_if.mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_we got=%b exp=0", mem_if.mem_we); end
        n_cmp++; if (mem_if.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mar got=%h exp=0000", mem_if.mem_addr); end
        n_cmp++; if (stk_err !== 1'b0) begin n_fail++; $display("FAIL reset_stk_err got=%b exp=0", stk_err); end
        rst_n = 1;
        cycle();
    endtask

    task automatic test_fetch();
        clr_ctl();
        load_ir(16'h0805);
        ipc = 1; cycle(); cycle(); cycle(); ipc = 0;
        n_cmp++; if (pc !== 8'h03)     begin n_fail++; $display("FAIL fetch_pc got=%h exp=03", pc); end
        n_cmp++; if (opcode !== 5'h01) begin n_fail++; $display("FAIL fetch_opcode got=%h exp=01", opcode); end
        n_cmp++; if (s !== 3'd0)       begin n_fail++; $display("FAIL fetch_s got=%h exp=0", s); end
        set_pc(8'hFE);
        n_cmp++; if (pc !== 8'hFE)     begin n_fail++; $display("FAIL wpc_load got=%h exp=fe", pc); end
        ipc = 1; cycle(); cycle(); ipc = 0;
        n_cmp++; if (pc !== 8'h00)     begin n_fail++; $display("FAIL pc_wrap got=%h exp=00", pc); end
        load_ir({5'h00, 3'd0, 8'h55});
        op = ALU_PASSB; inm = 1; ipc = 1; wpc = 1; cycle(); ipc = 0;
        n_cmp++; if (pc !== 8'h01)     begin n_fail++; $display("FAIL ipc_over_wpc got=%h exp=01", pc); end
        cycle(); wpc = 0; inm = 0;
        n_cmp++; if (pc !== 8'h55)     begin n_fail++; $display("FAIL wpc_bus got=%h exp=55", pc); end
    endtask

    task automatic test_alu_status();
        clr_ctl();
        load_reg(3'd1, 8'h01);
        load_ir({5'h00, 3'd1, 8'hFF});
        sesb = 1; cycle(); sesb = 0;
        n_cmp++; if (status !== 8'h02) begin n_fail++; $display("FAIL sesb_bit1 got=%h exp=02", status); end
        op = ALU_ADD; inm = 1; #1;
        n_cmp++; if (mem_if.mem_wdata !== 16'h0100) begin n_fail++; $display("FAIL add_result got=%h exp=0100", mem_if.mem_wdata); end
        wsreg = 1; cycle(); wsreg = 0;
        n_cmp++; if (status !== 8'h00) begin n_fail++; $display("FAIL add_status got=%h exp=00", status); end
        op = ALU_SUB; #1;
        n_cmp++; if (mem_if.mem_wdata !== 16'hFF02) begin n_fail++; $display("FAIL sub_result got=%h exp=ff02", mem_if.mem_wdata); end
        wsreg = 1; cycle(); wsreg = 0;
        n_cmp++; if (status !== 8'h05) begin n_fail++; $display("FAIL sub_status got=%h exp=05", status); end
        load_ir({5'h00, 3'd1, 8'h01});
        op = ALU_XOR; inm = 1; wsreg = 1; clsb = 1; cycle(); wsreg = 0;
        n_cmp++; if (status !== 8'h02) begin n_fail++; $display("FAIL wsreg_over_clsb got=%h exp=02", status); end
        cycle(); clsb = 0; inm = 0;
        n_cmp++; if (status !== 8'h00) begin n_fail++; $display("FAIL clsb_bit1 got=%h exp=00", status); end
        load_ir({5'h00, 3'd7, 8'h00});
        sesb = 1; clsb = 1; cycle(); clsb = 0;
        n_cmp++; if (status !== 8'h00) begin n_fail++; $display("FAIL clsb_over_sesb got=%h exp=00", status); end
        cycle(); sesb = 0;
        n_cmp++; if (status !== 8'h80) begin n_fail++; $display("FAIL sesb_bit7 got=%h exp=80", status); end
    endtask

    task automatic test_mem_read();
        int nbusy;
        logic [15:0] v;
        clr_ctl();
        load_ir({5'h00, 3'd3, 8'h10});
        op = ALU_PASSB; inm = 1; wmar = 1; cycle(); wmar = 0;
        n_cmp++; if (mem_if.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL mar_load got=%h exp=0010", mem_if.mem_addr); end
        rmem = 1; cycle(); rmem = 0;
        nbusy = 0;
        n_cmp++; if (mem_if.mem_req !== 1'b1) begin n_fail++; $display("FAIL rd_req got=%b exp=1", mem_if.mem_req); end
        n_cmp++; if (mem_if.mem_we !== 1'b0)  begin n_fail++; $display("FAIL rd_we got=%b exp=0", mem_if.mem_we); end
        if (busy) nbusy++;
        load_ir({5'h00, 3'd3, 8'h20});
        if (busy) nbusy++;
        op = ALU_PASSB; inm = 1; wmar = 1; rmem = 1; cycle(); wmar = 0; rmem = 0;
        if (busy) nbusy++;
        n_cmp++; if (mem_if.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL rd_addr_hold got=%h exp=0010", mem_if.mem_addr); end
        mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h00A5; wreg = 1;
        cycle();
        mem_if.mem_ack = 0; wreg = 0; inm = 0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_done_busy got=%b exp=0", busy); end
        n_cmp++; if (nbusy !== 3)   begin n_fail++; $display("FAIL rd_busy_cycles got=%0d exp=3", nbusy); end
        n_cmp++; if (mem_if.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL mar_during_wait got=%h exp=0020", mem_if.mem_addr); end
        read_reg(3'd3, v);
        n_cmp++; if (v !== 16'h00A5) begin n_fail++; $display("FAIL rd_data_wins got=%h exp=00a5", v); end
    endtask

    task automatic test_mem_write();
        logic [15:0] v;
        clr_ctl();
        load_reg(3'd2, 8'h11);
        load_ir({5'h00, 3'd2, 8'h5A});
        op = ALU_PASSB; inm = 1; wmem = 1; cycle(); wmem = 0;
        n_cmp++; if (mem_if.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_we got=%b exp=1", mem_if.mem_we); end
        n_cmp++; if (mem_if.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL wr_addr got=%h exp=0020", mem_if.mem_addr); end
        load_ir({5'h00, 3'd2, 8'h33});
        n_cmp++; if (mem_if.mem_wdata !== 16'h005A) begin n_fail++; $display("FAIL wr_data_hold got=%h exp=005a", mem_if.mem_wdata); end
        mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h00EE; cycle(); mem_if.mem_ack = 0; inm = 0;
        n_cmp++; if (mem_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_done_we got=%b exp=0", mem_if.mem_we); end
        read_reg(3'd2, v);
        n_cmp++; if (v !== 16'h0011) begin n_fail++; $display("FAIL wr_no_regwrite got=%h exp=0011", v); end
        load_ir({5'h00, 3'd2, 8'h00});
        rmem = 1; wmem = 1; cycle(); rmem = 0; wmem = 0;
        n_cmp++; if (mem_if.mem_we !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rw_as_read we=%b busy=%b exp we=0 busy=1", mem_if.mem_we, busy); end
        mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h0077; cycle(); mem_if.mem_ack = 0;
        read_reg(3'd2, v);
        n_cmp++; if (v !== 16'h0077) begin n_fail++; $display("FAIL rw_read_data got=%h exp=0077", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        clr_ctl();
        load_reg(3'd4, 8'h22);
        load_ir({5'h00, 3'd4, 8'h00});
        rmem = 1; cycle(); rmem = 0;
        n_cmp++; if (mem_if.mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_before got=%b exp=1", mem_if.mem_req); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (mem_if.mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop req=%b busy=%b exp 0 0", mem_if.mem_req, busy); end
        cycle();
        rst_n = 1;
        mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h0099; cycle(); mem_if.mem_ack = 0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
        read_reg(3'd4, v);
        n_cmp++; if (v !== 16'h0022) begin n_fail++; $display("FAIL mid_no_regwrite got=%h exp=0022", v); end
    endtask

`ifdef YASAC_RSTACK_EN
    task automatic test_call_ret();
        logic [7:0] exp_ret [4];
        exp_ret = '{8'h41, 8'h41, 8'h41, 8'h03};
        clr_ctl();
        clpc = 1; cycle(); clpc = 0;
        set_pc(8'h02);
        load_ir({5'h00, 3'd0, 8'h40});
        op = ALU_PASSB; inm = 1;
        call = 1; cycle();
        n_cmp++; if (pc !== 8'h40 || stk_err !== 1'b0) begin n_fail++; $display("FAIL call1 pc=%h err=%b exp 40 0", pc, stk_err); end
        cycle(); cycle(); cycle();
        n_cmp++; if (stk_err !== 1'b0) begin n_fail++; $display("FAIL call4_err got=%b exp=0", stk_err); end
        cycle(); call = 0;
        n_cmp++; if (pc !== 8'h40 || stk_err !== 1'b1) begin n_fail++; $display("FAIL call5_full pc=%h err=%b exp 40 1", pc, stk_err); end
        for (int i = 0; i < 4; i++) begin
            ret = 1; cycle(); ret = 0;
            n_cmp++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ret%0d got=%h exp=%h", i, pc, exp_ret[i]); end
        end
        ret = 1; cycle(); ret = 0;
        n_cmp++; if (pc !== 8'h03 || stk_err !== 1'b1) begin n_fail++; $display("FAIL ret_extra pc=%h err=%b exp 03 1", pc, stk_err); end
        clpc = 1; cycle(); clpc = 0;
        call = 1; ipc = 1; cycle(); ipc = 0;
        n_cmp++; if (pc !== 8'h40) begin n_fail++; $display("FAIL call_over_ipc got=%h exp=40", pc); end
        ret = 1; cycle(); ret = 0; call = 0; inm = 0;
        n_cmp++; if (pc !== 8'h01 || stk_err !== 1'b0) begin n_fail++; $display("FAIL ret_over_call pc=%h err=%b exp 01 0", pc, stk_err); end
    endtask

    task automatic test_ret_empty();
        clr_ctl();
        clpc = 1; cycle(); clpc = 0;
        set_pc(8'h07);
        ret = 1; cycle(); ret = 0;
        n_cmp++; if (pc !== 8'h07 || stk_err !== 1'b1) begin n_fail++; $display("FAIL ret_empty pc=%h err=%b exp 07 1", pc, stk_err); end
        clpc = 1; cycle(); clpc = 0;
        n_cmp++; if (pc !== 8'h00 || stk_err !== 1'b0) begin n_fail++; $display("FAIL clpc_clear pc=%h err=%b exp 00 0", pc, stk_err); end
    endtask
`else
    task automatic test_no_stack();
        clr_ctl();
        set_pc(8'h07);
        load_ir({5'h00, 3'd0, 8'h40});
        op = ALU_PASSB; inm = 1; call = 1; cycle(); call = 0;
        n_cmp++; if (pc !== 8'h07 || stk_err !== 1'b0) begin n_fail++; $display("FAIL call_ignored pc=%h err=%b exp 07 0", pc, stk_err); end
        ret = 1; ipc = 1; cycle(); ret = 0; ipc = 0; inm = 0;
        n_cmp++; if (pc !== 8'h08 || stk_err !== 1'b0) begin n_fail++; $display("FAIL ret_ignored pc=%h err=%b exp 08 0", pc, stk_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_alu_status();
        test_mem_read();
        test_mem_write();
        test_reset_mid();
`ifdef YASAC_RSTACK_EN
        test_call_ret();
        test_ret_empty();
`else
        test_no_stack();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
